// File: rtl/interrupt_sequencer.sv
// 8259A-style interrupt acknowledge sequencer: priority resolve, ISR, EOI, rotation.
// Optional polled-mode read enabled by defining INT_SEQ_POLL_EN (adds poll_cmd).
module interrupt_sequencer #(
  parameter int NUM_IR         = 8,
  parameter int SPURIOUS_LEVEL = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IR-1:0] irr,
  input  logic [NUM_IR-1:0] imr,
  input  logic [4:0]        vector_base,
  input  logic              aeoi,
  input  logic              auto_rotate,
  input  logic              inta_strobe,
  input  logic              eoi_cmd,
  input  logic              eoi_specific,
  input  logic [2:0]        eoi_level,
`ifdef INT_SEQ_POLL_EN
  input  logic              poll_cmd,
`endif
  output logic              int_out,
  output logic [NUM_IR-1:0] clear_irr,
  output logic [NUM_IR-1:0] isr,
  output logic [2:0]        priority_rotate,
  output logic [7:0]        data_out,
  output logic              data_out_en
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK2 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [NUM_IR-1:0] isr_q, isr_d;
  logic [NUM_IR-1:0] clr_q, clr_d;
  logic [2:0]        rot_q, rot_d;
  logic [2:0]        lvl_q, lvl_d;
  logic              spur_q, spur_d;
  logic [7:0]        dout_q, dout_d;
  logic              den_q, den_d;

  logic [NUM_IR-1:0] isr_set, isr_clr;
  logic [3:0]        req_rank, isr_rank;
  logic [2:0]        cand_lvl, isr_lvl;
  logic              cand_vld;

  // Rank 0 is level rot+1; returns 8 when no bit is set.
  function automatic logic [3:0] top_rank(input logic [7:0] v,
                                          input logic [2:0] rot);
    logic [3:0] r;
    logic [2:0] lvl;
    r = 4'd8;
    for (int k = 7; k >= 0; k--) begin
      lvl = rot + 3'd1 + 3'(k);
      if (v[lvl]) r = 4'(k);
    end
    return r;
  endfunction

  always_comb begin
    req_rank = top_rank(irr & ~imr, rot_q);
    isr_rank = top_rank(isr_q, rot_q);
    cand_vld = (req_rank < isr_rank);
    cand_lvl = rot_q + 3'd1 + req_rank[2:0];
    isr_lvl  = rot_q + 3'd1 + isr_rank[2:0];
  end

  always_comb begin
    state_d = state_q;
    isr_set = '0;
    isr_clr = '0;
    rot_d   = rot_q;
    lvl_d   = lvl_q;
    spur_d  = spur_q;
    clr_d   = '0;
    dout_d  = dout_q;
    den_d   = 1'b0;

    if (eoi_cmd) begin
      if (eoi_specific) begin
        isr_clr[eoi_level] = 1'b1;
      end else if (isr_rank != 4'd8) begin
        isr_clr[isr_lvl] = 1'b1;
        if (auto_rotate) rot_d = isr_lvl;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (cand_vld) state_d = REQ;
      end
      REQ: begin
        if (inta_strobe) begin
          state_d = ACK2;
          if (cand_vld) begin
            lvl_d             = cand_lvl;
            spur_d            = 1'b0;
            isr_set[cand_lvl] = 1'b1;
            clr_d[cand_lvl]   = 1'b1;
          end else begin
            lvl_d  = 3'(SPURIOUS_LEVEL);
            spur_d = 1'b1;
          end
        end
      end
      ACK2: begin
        if (inta_strobe) begin
          state_d = IDLE;
          dout_d  = {vector_base, lvl_q};
          den_d   = 1'b1;
          if (aeoi && !spur_q) begin
            isr_clr[lvl_q] = 1'b1;
            if (auto_rotate) rot_d = lvl_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef INT_SEQ_POLL_EN
    // A poll read acts as a complete acknowledge in one step.
    if (poll_cmd && state_q != ACK2) begin
      state_d = IDLE;
      den_d   = 1'b1;
      if (cand_vld) begin
        dout_d            = {1'b1, 4'b0, cand_lvl};
        isr_set[cand_lvl] = 1'b1;
        clr_d[cand_lvl]   = 1'b1;
      end else begin
        dout_d = 8'h00;
      end
    end
`endif

    isr_d = (isr_q & ~isr_clr) | isr_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      isr_q   <= '0;
      clr_q   <= '0;
      rot_q   <= 3'd7;
      lvl_q   <= 3'd0;
      spur_q  <= 1'b0;
      dout_q  <= 8'h00;
      den_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      isr_q   <= isr_d;
      clr_q   <= clr_d;
      rot_q   <= rot_d;
      lvl_q   <= lvl_d;
      spur_q  <= spur_d;
      dout_q  <= dout_d;
      den_q   <= den_d;
    end
  end

  assign int_out         = (state_q == REQ);
  assign clear_irr       = clr_q;
  assign isr             = isr_q;
  assign priority_rotate = rot_q;
  assign data_out        = dout_q;
  assign data_out_en     = den_q;

endmodule
